// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter. A word is accepted over a valid/ready
// handshake and shifted out one bit per rising edge on q, framed by q_valid
// and last. Back-to-back words are sent with no idle gap, and stall freezes
// the output mid-word. All outputs except load_ready are registered.
module shift_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             stall,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_q, w_q_nxt;
  logic             r_q_valid, w_q_valid_nxt;
  logic             r_last, w_last_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_word_end;
  logic             w_accept;

  // Bit that leaves the word first, selected by the transmit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? word[0] : word[WIDTH-1];
  endfunction

  // Move the word one place toward its output end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? {1'b0, word[WIDTH-1:1]} : {word[WIDTH-2:0], 1'b0};
  endfunction

  // A new word may be taken when idle, or on the final unstalled bit so
  // consecutive words leave without a gap.
  assign w_word_end = (r_state == S_SHIFT) && (r_count == LAST_CNT) && !stall;
  assign load_ready = (r_state == S_IDLE) || w_word_end;
  assign w_accept   = load_valid && load_ready;

  // Next-state and next-output logic; everything holds unless updated.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_shreg_nxt   = r_shreg;
    w_q_nxt       = r_q;
    w_q_valid_nxt = r_q_valid;
    w_last_nxt    = r_last;
    w_busy_nxt    = r_busy;
    if (w_accept) begin
      // Capture: the first bit goes straight to q, the rest waits in the
      // shift register already advanced by one place.
      w_state_nxt   = S_SHIFT;
      w_count_nxt   = '0;
      w_shreg_nxt   = shift_out(load_data);
      w_q_nxt       = first_bit(load_data);
      w_q_valid_nxt = 1'b1;
      w_last_nxt    = 1'b0;
      w_busy_nxt    = 1'b1;
    end else if (w_word_end) begin
      w_state_nxt   = S_IDLE;
      w_count_nxt   = '0;
      w_shreg_nxt   = '0;
      w_q_nxt       = 1'b0;
      w_q_valid_nxt = 1'b0;
      w_last_nxt    = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if ((r_state == S_SHIFT) && !stall) begin
      w_count_nxt = r_count + 1'b1;
      w_shreg_nxt = shift_out(r_shreg);
      w_q_nxt     = first_bit(r_shreg);
      w_last_nxt  = (w_count_nxt == LAST_CNT);
    end
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_shreg   <= '0;
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_shreg   <= w_shreg_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign last    = r_last;
  assign busy    = r_busy;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: an MSB-first and an LSB-first
// instance are driven by the same inputs and checked against hand-derived
// bit sequences.
module tb_shift_serializer;

  logic       clock;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       stall;
  logic       m_ready, m_q, m_qv, m_last, m_busy;
  logic       l_ready, l_q, l_qv, l_last, l_busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(m_ready),
    .load_data(load_data), .stall(stall), .q(m_q), .q_valid(m_qv), .last(m_last), .busy(m_busy)
  );

  shift_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(l_ready),
    .load_data(load_data), .stall(stall), .q(l_q), .q_valid(l_qv), .last(l_last), .busy(l_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Both instances idle with all outputs cleared.
  task automatic check_idle(input string tag);
    check({tag, "_m_q"}, m_q, 1'b0);
    check({tag, "_m_qv"}, m_qv, 1'b0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_m_busy"}, m_busy, 1'b0);
    check({tag, "_m_ready"}, m_ready, 1'b1);
    check({tag, "_l_q"}, l_q, 1'b0);
    check({tag, "_l_qv"}, l_qv, 1'b0);
    check({tag, "_l_busy"}, l_busy, 1'b0);
  endtask

  // Present a word and let one edge accept it.
  task automatic load(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    check("load_ready", m_ready, 1'b1);
    tick();
    load_valid = 1'b0;
  endtask

  // Check the eight bit-times of word w; optionally stall 3 cycles at count==stall_at.
  task automatic expect_word(input logic [7:0] w, input int stall_at);
    for (int k = 0; k < 8; k++) begin
      check("m_q", m_q, w[7-k]);
      check("l_q", l_q, w[k]);
      check("m_qv", m_qv, 1'b1);
      check("l_qv", l_qv, 1'b1);
      check("m_last", m_last, k == 7);
      check("l_last", l_last, k == 7);
      check("m_busy", m_busy, 1'b1);
      check("m_ready", m_ready, k == 7);
      if (k == stall_at) begin
        stall = 1'b1;
        repeat (3) begin
          tick();
          check("stall_m_q", m_q, w[7-k]);
          check("stall_l_q", l_q, w[k]);
          check("stall_qv", m_qv, 1'b1);
          check("stall_last", m_last, 1'b0);
          check("stall_ready", m_ready, 1'b0);
        end
        stall = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    stall      = 1'b0;

    // Reset asserted before any clock edge: outputs clear asynchronously.
    #2 reset_n = 1'b0;
    #1 check_idle("rst_async");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("rst_release");

    // Single word 8'hA5, then back to idle.
    load(8'hA5);
    expect_word(8'hA5, -1);
    check_idle("after_a5");

    // 8'h01: MSB-first sends seven 0s then 1, LSB-first sends 1 then zeros.
    load(8'h01);
    expect_word(8'h01, -1);
    check_idle("after_01");

    // Back-to-back: second word held on load_valid until accepted at the word end.
    load_valid = 1'b1;
    load_data  = 8'hF0;
    tick();
    load_data  = 8'h0F;
    expect_word(8'hF0, -1);
    load_valid = 1'b0;
    expect_word(8'h0F, -1);
    check_idle("after_b2b");

    // Stall for 3 cycles at count==3.
    load(8'hA5);
    expect_word(8'hA5, 3);
    check_idle("after_stall");

    // Reset mid-word at count==4, between clock edges.
    load(8'hA5);
    repeat (4) tick();
    check("pre_rst_qv", m_qv, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_idle("rst_mid");
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("rst_mid_release");
    load(8'h3C);
    expect_word(8'h3C, -1);
    check_idle("after_3c");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
